// File: rtl/crypto1_pkg.sv
// Shared definitions for the Crypto1 key-search datapath: subkey width,
// default replay ring depth and the compare-core state encoding.
package crypto1_pkg;

    localparam int SUBKEY_W   = 24;
    localparam int RING_DEPTH = 16;

    typedef enum logic [1:0] {
        WAIT_FULL,
        COMPARE,
        FINISHED
    } state_t;

endpackage

// File: rtl/subkey_ring_mem.sv
// WIDTH x DEPTH register array, one write port and one registered read port.
// The read register holds its value between reads and clears on reset.
module subkey_ring_mem
    import crypto1_pkg::*;
#(
    parameter int WIDTH = SUBKEY_W,
    parameter int DEPTH = RING_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RESETn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage is not reset; only the presented read word is.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/subkey_ring_buf.sv
// Loads a batch of up to DEPTH subkeys from the upstream generator FIFO, then
// replays them cyclically for the compare engine until the consumer resets it.
//
//   state     | meaning
//   WAIT_FULL | filling from the upstream FIFO; replay blocked
//   COMPARE   | batch loaded (FULL=1); RDEN replays entries cyclically
//   FINISHED  | upstream exhausted with nothing loaded; DONE=1, FULL stays 0
module subkey_ring_buf
    import crypto1_pkg::*;
#(
    parameter int DEPTH = RING_DEPTH,
    parameter int WIDTH = SUBKEY_W
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [WIDTH-1:0] FIFO_RDDATA,
    output logic             FIFO_RDEN,
    input  logic             FIFO_RDEMPTY,
    input  logic             FIFO_DONE,
    input  logic             RDEN,
    output logic [WIDTH-1:0] RDDATA,
    output logic             FULL,
    output logic             DONE,
    output logic             END
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          inflight_q, inflight_d;
    logic          fifo_rden_q, fifo_rden_d;
    logic          done_q, done_d;
    logic          end_q, end_d;

    logic [CW:0]   pending;
    logic          src_exhausted;
    logic          rd_accept;
    logic          rd_last;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = fifo_rden_q;
        fifo_rden_d = 1'b0;
        end_d       = 1'b0;
        rd_accept   = 1'b0;

        src_exhausted = FIFO_DONE & FIFO_RDEMPTY;
        // Entries stored plus reads still on their way in.
        pending = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} + {{CW{1'b0}}, fifo_rden_q};
        rd_last = (CW'(rd_ptr_q) == (count_q - CW'(1)));

        if (inflight_q) begin
            count_d  = count_q + CW'(1);
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
        end

        case (state_q)
            WAIT_FULL: begin
                // One read outstanding at a time so a registered strobe never
                // pops a FIFO that the previous read has just drained.
                fifo_rden_d = ~FIFO_RDEMPTY & ~fifo_rden_q & (pending < DEPTH_W);
                if (!inflight_q && !fifo_rden_q) begin
                    if ({1'b0, count_q} == DEPTH_W) begin
                        state_d = COMPARE;
                    end else if (src_exhausted) begin
                        state_d = (count_q != '0) ? COMPARE : FINISHED;
                    end
                end
            end
            COMPARE: begin
                rd_accept = RDEN;
                if (RDEN) begin
                    rd_ptr_d = rd_last ? '0 : rd_ptr_q + AW'(1);
                    end_d    = rd_last;
                end
            end
            default: begin
            end
        endcase

        done_d = done_q | ((state_d != WAIT_FULL) & src_exhausted);
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= WAIT_FULL;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            fifo_rden_q <= 1'b0;
            done_q      <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            fifo_rden_q <= fifo_rden_d;
            done_q      <= done_d;
            end_q       <= end_d;
        end
    end

    subkey_ring_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .wr_en   (inflight_q),
        .wr_addr (wr_ptr_q),
        .wr_data (FIFO_RDDATA),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q),
        .rd_data (RDDATA)
    );

    assign FIFO_RDEN = fifo_rden_q;
    assign FULL      = (state_q == COMPARE);
    assign DONE      = done_q;
    assign END       = end_q;

endmodule

// File: tb/tb_subkey_ring_buf.sv
// Directed bench for subkey_ring_buf (DEPTH=4): the upstream generator is a
// queue-backed FIFO; replay is checked from per-test vector tables.
module tb_subkey_ring_buf;

    localparam int DEPTH = 4;
    localparam int W     = 24;

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic [W-1:0] FIFO_RDDATA = '0;
    logic         FIFO_RDEN;
    logic         FIFO_RDEMPTY = 1'b1;
    logic         FIFO_DONE = 1'b0;
    logic         RDEN = 1'b0;
    logic [W-1:0] RDDATA;
    logic         FULL;
    logic         DONE;
    logic         end_o;

    subkey_ring_buf #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .FIFO_RDDATA  (FIFO_RDDATA),
        .FIFO_RDEN    (FIFO_RDEN),
        .FIFO_RDEMPTY (FIFO_RDEMPTY),
        .FIFO_DONE    (FIFO_DONE),
        .RDEN         (RDEN),
        .RDDATA       (RDDATA),
        .FULL         (FULL),
        .DONE         (DONE),
        .END          (end_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         rden;
        logic [W-1:0] rddata;
        logic         end_exp;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] fifo[$];
    int           errors = 0;
    int           checks = 0;
    int           rden_cnt = 0;
    bit           bursty = 1'b0;
    bit           phase = 1'b0;
    logic [W-1:0] src_next = '0;
    int           src_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: serve a pending FIFO read, advance, then update the FIFO model.
    task automatic tick();
        logic         pop;
        logic [W-1:0] d;
        pop = FIFO_RDEN;
        d   = FIFO_RDDATA;
        if (pop === 1'b1) begin
            chk("rden_while_empty", {31'd0, FIFO_RDEMPTY}, 32'd0);
            rden_cnt++;
            if (fifo.size() > 0) d = fifo.pop_front();
        end
        @(posedge CLK);
        #1;
        FIFO_RDDATA = d;
        if (bursty) begin
            phase = ~phase;
            if (phase && src_left > 0) begin
                fifo.push_back(src_next);
                src_next = src_next + 1'b1;
                src_left--;
            end
        end
        FIFO_RDEMPTY = (fifo.size() == 0);
    endtask

    task automatic do_reset(input string tag);
        RDEN   = 1'b0;
        RESETn = 1'b0;
        tick();
        chk({tag, "_rst_full"},  {31'd0, FULL},      32'd0);
        chk({tag, "_rst_done"},  {31'd0, DONE},      32'd0);
        chk({tag, "_rst_end"},   {31'd0, end_o},     32'd0);
        chk({tag, "_rst_rden"},  {31'd0, FIFO_RDEN}, 32'd0);
        chk({tag, "_rst_data"},  {8'd0, RDDATA},     32'd0);
        RESETn   = 1'b1;
        rden_cnt = 0;
    endtask

    task automatic wait_full(input string tag);
        int n;
        n = 0;
        while (FULL !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_full"}, {31'd0, FULL}, 32'd1);
    endtask

    task automatic add_vec(input logic rden, input logic [W-1:0] data, input logic e);
        vec_t v;
        v.rden    = rden;
        v.rddata  = data;
        v.end_exp = e;
        vecs.push_back(v);
    endtask

    task automatic apply_vecs(input string tag);
        foreach (vecs[i]) begin
            RDEN = vecs[i].rden;
            tick();
            chk($sformatf("%s_data%0d", tag, i), {8'd0, RDDATA},     {8'd0, vecs[i].rddata});
            chk($sformatf("%s_end%0d", tag, i),  {31'd0, end_o},     {31'd0, vecs[i].end_exp});
        end
        RDEN = 1'b0;
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset("rst0");

        // Full batch from a never-empty source.
        for (int i = 1; i <= 6; i++) fifo.push_back(W'(i));
        FIFO_RDEMPTY = 1'b0;
        wait_full("t1");
        repeat (4) tick();
        chk("t1_rden_pulses", rden_cnt, 32'd4);
        chk("t1_fifo_left", fifo.size(), 32'd2);
        chk("t1_done", {31'd0, DONE}, 32'd0);
        add_vec(1, 24'h1, 0); add_vec(1, 24'h2, 0); add_vec(1, 24'h3, 0);
        add_vec(1, 24'h4, 1); add_vec(1, 24'h1, 0); add_vec(1, 24'h2, 0);
        add_vec(0, 24'h2, 0);
        apply_vecs("t1");
        chk("t1_done_after", {31'd0, DONE}, 32'd0);

        // Two more reads, then flush mid-replay and load the next batch.
        add_vec(1, 24'h3, 0); add_vec(1, 24'h4, 1);
        apply_vecs("t5_pre");
        do_reset("t5");
        fifo.push_back(24'h7);
        fifo.push_back(24'h8);
        FIFO_RDEMPTY = 1'b0;
        wait_full("t5");
        repeat (2) tick();
        chk("t5_rden_pulses", rden_cnt, 32'd4);
        chk("t5_fifo_left", fifo.size(), 32'd0);

        // Gapped reads: one accepted RDEN every third cycle.
        for (int k = 0; k < 5; k++) begin
            add_vec(1, W'(5 + (k % 4)), (k % 4) == 3);
            add_vec(0, W'(5 + (k % 4)), 0);
            add_vec(0, W'(5 + (k % 4)), 0);
        end
        apply_vecs("t6");

        // Partial last batch.
        do_reset("t2");
        fifo.delete();
        fifo.push_back(24'hA);
        fifo.push_back(24'hB);
        FIFO_DONE    = 1'b1;
        FIFO_RDEMPTY = 1'b0;
        wait_full("t2");
        tick();
        chk("t2_done", {31'd0, DONE}, 32'd1);
        chk("t2_rden_pulses", rden_cnt, 32'd2);
        add_vec(1, 24'hA, 0); add_vec(1, 24'hB, 1);
        add_vec(1, 24'hA, 0); add_vec(1, 24'hB, 1);
        add_vec(0, 24'hB, 0);
        apply_vecs("t2");

        // Exhausted source with nothing to load.
        do_reset("t3");
        fifo.delete();
        FIFO_RDEMPTY = 1'b1;
        repeat (10) tick();
        chk("t3_full", {31'd0, FULL}, 32'd0);
        chk("t3_done", {31'd0, DONE}, 32'd1);
        chk("t3_rden_pulses", rden_cnt, 32'd0);
        add_vec(1, 24'h0, 0); add_vec(1, 24'h0, 0); add_vec(1, 24'h0, 0);
        apply_vecs("t3");
        chk("t3_full_after", {31'd0, FULL}, 32'd0);

        // Bursty source: a new subkey arrives every other cycle.
        FIFO_DONE = 1'b0;
        do_reset("t4");
        fifo.delete();
        FIFO_RDEMPTY = 1'b1;
        src_next = 24'h100;
        src_left = 6;
        bursty   = 1'b1;
        wait_full("t4");
        repeat (8) tick();
        bursty = 1'b0;
        chk("t4_rden_pulses", rden_cnt, 32'd4);
        chk("t4_fifo_left", fifo.size(), 32'd2);
        chk("t4_done", {31'd0, DONE}, 32'd0);
        add_vec(1, 24'h100, 0); add_vec(1, 24'h101, 0); add_vec(1, 24'h102, 0);
        add_vec(1, 24'h103, 1); add_vec(1, 24'h100, 0);
        apply_vecs("t4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
